spi_poll_scheduler: RTL and testbench
=====================================

// Module: spi_poll_scheduler
// PURPOSE
//  Sequences periodic 5-byte SPI read transactions from the joystick/sensor slave feeding servo steering.
//  Acts as SPI master (mode 0): generates ss_n, sclk and mosi, shifts miso, and decides when a frame runs.
//  A frame starts on the internal poll timer or an on-demand poll_now request.
//  Publishes each completed frame atomically, with a 1-cycle frame_valid strobe, to downstream servo logic.
// PARAMETERS
//  BYTES       5          bytes per frame; frame width = 8*BYTES
//  CLK_DIV     50         clk cycles per sclk half-period (100 MHz -> 1 MHz sclk); >= 1
//  SS_SETUP    1500       cycles ss_n low before bit 0 low phase begins (15 us); >= 1
//  BYTE_GAP    1000       sclk-low idle cycles between bytes (10 us); >= 1
//  POLL_PERIOD 1_000_000  clk cycles between timer triggers (10 ms); >= 2
// PORTS
//  clk          in   1         system clock; all logic on posedge
//  rst          in   1         synchronous reset, active-high
//  enable       in   1         1 = poll timer runs; 0 = timer cleared and held
//  poll_now     in   1         1-cycle request for an immediate frame
//  cmd_in       in   8         command byte; sampled at trigger, sent as byte 0 on mosi
//  miso         in   1         serial data from slave
//  ss_n         out  1         slave select, active-low
//  sclk         out  1         SPI clock, idle low
//  mosi         out  1         serial data to slave
//  frame        out  8*BYTES   last complete frame; byte 0 in [8*BYTES-1 -: 8]; MSB first
//  frame_valid  out  1         1-cycle pulse, asserted in the cycle frame updates
//  busy         out  1         1 whenever FSM != IDLE
//  overrun      out  1         1-cycle pulse: trigger arrived while busy and was dropped
// BEHAVIOUR
//  Reset: ss_n=1, sclk=0, mosi=0, frame=0, frame_valid=0, busy=0, overrun=0.
//   Timer=0; FSM=IDLE; partial shift data discarded.
//  Timer: counts 0..POLL_PERIOD-1 while enable=1; tick when count==POLL_PERIOD-1, then wraps to 0.
//   Keeps counting during frames; enable=0 clears it next cycle.
//  Trigger = tick | poll_now.
//   Trigger in IDLE (cycle T): latch cmd_in; go to SETUP; ss_n=0 from T+1.
//   Tick and poll_now in the same cycle: one frame, no overrun.
//   Trigger while busy: dropped; overrun pulses the next cycle.
//  FSM IDLE -> SETUP -> SHIFT -> (GAP -> SHIFT)* -> TAIL -> DONE -> IDLE.
//   SETUP: SS_SETUP cycles; sclk=0; mosi = cmd bit 7.
//   SHIFT: 8 bits. Each bit is CLK_DIV cycles sclk=0 followed by CLK_DIV cycles sclk=1.
//    miso is sampled into the shift register on the clk edge where sclk rises.
//    mosi updates when sclk falls; mosi=0 for bytes 1..BYTES-1.
//   GAP: BYTE_GAP cycles; sclk=0; ss_n=0. Entered after bytes 0..BYTES-2 only.
//   TAIL: CLK_DIV cycles; sclk=0; ss_n=0.
//   DONE: 1 cycle. ss_n=1, frame<=shift register, frame_valid=1, mosi=0.
//  ss_n low for exactly SS_SETUP + BYTES*16*CLK_DIV + (BYTES-1)*BYTE_GAP + CLK_DIV cycles.
//  frame is held between DONE cycles; no partial frame is ever visible.
//  Byte and bit counters: byte 0..BYTES-1, bit 7..0; no wrap beyond BYTES.
//  enable->0 mid-frame: the frame completes normally.
//  rst mid-frame: all outputs take reset values next edge; ss_n=1 immediately.
//  Minimum ss_n high time between frames: 2 cycles (DONE + IDLE).
// TESTING (CLK_DIV=2, SS_SETUP=4, BYTE_GAP=3, POLL_PERIOD=1000, BYTES=5 unless noted)
//  1 poll_now at T, miso model returns 0xA5_3C_0F_F0_81, cmd_in=0x83
//    -> ss_n low T+1..T+178; sclk first rises T+7
//    -> frame=0xA53C0FF081 and frame_valid=1 at T+179 only; mosi carries 0x83 on byte 0
//  2 enable=1 from reset, poll_now never asserted
//    -> frames start at count 999, ~every 1000 cycles
//    -> exactly one frame_valid per period; overrun stays 0
//  3 poll_now at T+50 during a frame
//    -> overrun=1 at T+51; frame in progress is unchanged
//    -> no second frame; busy deasserts at T+180
//  4 tick and poll_now in the same IDLE cycle
//    -> one frame only; overrun=0
//  5 rst at T+100 mid-frame
//    -> ss_n=1, sclk=0, frame=0, busy=0 after that edge
//    -> next poll_now gives a clean full frame
//  6 enable 1->0 at T+60 mid-frame
//    -> frame completes with frame_valid at T+179; timer=0, no further ticks

Source files
------------

// File: rtl/spi_poll_scheduler.sv
// spi_poll_scheduler
//   Mode-0 SPI master that periodically reads a fixed-length frame from the
//   joystick/sensor slave and hands each completed frame to the servo logic
//   in one atomic update.
//
// Ports
//   clk, rst     system clock; synchronous active-high reset
//   enable       runs the poll timer; low clears and holds it
//   poll_now     single-cycle request for an immediate frame
//   cmd_in       command byte, latched at trigger and sent as byte 0
//   miso         serial data from the slave
//   ss_n, sclk,  SPI master outputs (slave select, clock idle low, data)
//   mosi
//   frame        last complete frame, byte 0 in the top byte, MSB first
//   frame_valid  one-cycle strobe in the cycle frame updates
//   busy         high whenever a transaction is in progress
//   overrun      one-cycle strobe when a trigger was dropped because busy
module spi_poll_scheduler #(
  parameter int BYTES       = 5,
  parameter int CLK_DIV     = 50,
  parameter int SS_SETUP    = 1500,
  parameter int BYTE_GAP    = 1000,
  parameter int POLL_PERIOD = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               poll_now,
  input  logic [7:0]         cmd_in,
  input  logic               miso,
  output logic               ss_n,
  output logic               sclk,
  output logic               mosi,
  output logic [8*BYTES-1:0] frame,
  output logic               frame_valid,
  output logic               busy,
  output logic               overrun
);

  localparam int FW = 8 * BYTES;
  localparam int TW = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
  localparam int BW = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [TW-1:0] TICK_AT    = TW'(POLL_PERIOD - 1);
  localparam logic [31:0]   SETUP_LAST = 32'(SS_SETUP - 1);
  localparam logic [31:0]   HALF_LAST  = 32'(CLK_DIV - 1);
  localparam logic [31:0]   GAP_LAST   = 32'(BYTE_GAP - 1);
  localparam logic [BW-1:0] LAST_BYTE  = BW'(BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP,
    TAIL,
    DONE
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [31:0]   cnt;
  logic [2:0]    bit_cnt;
  logic [BW-1:0] byte_cnt;
  logic [7:0]    cmd;
  logic [FW-1:0] shift_reg;
  logic          tick;
  logic          trigger;

  assign tick    = enable && (timer == TICK_AT);
  assign trigger = tick || poll_now;
  assign busy    = (state != IDLE);

  // Free-running poll timer; it keeps counting while a frame is on the wire
  // so the poll cadence does not drift with frame length.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      timer <= '0;
    end else if (timer == TICK_AT) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Transaction FSM. All SPI pins and frame outputs are registered here.
  // cnt times every phase; in SHIFT it times one sclk half-period and the
  // registered sclk tells which half we are in. miso is captured on the
  // edge that raises sclk, mosi moves on the edge that lowers it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ss_n        <= 1'b1;
      sclk        <= 1'b0;
      mosi        <= 1'b0;
      frame       <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      cnt         <= '0;
      bit_cnt     <= 3'd7;
      byte_cnt    <= '0;
      cmd         <= '0;
      shift_reg   <= '0;
    end else begin
      frame_valid <= 1'b0;
      overrun     <= trigger && (state != IDLE);
      case (state)
        IDLE: begin
          if (trigger) begin
            state    <= SETUP;
            cmd      <= cmd_in;
            ss_n     <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= cmd_in[7];
            cnt      <= '0;
            bit_cnt  <= 3'd7;
            byte_cnt <= '0;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!sclk) begin
              sclk      <= 1'b1;
              shift_reg <= {shift_reg[FW-2:0], miso};
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == 3'd0) begin
                // Only byte 0 carries the command; later bytes send zeros.
                mosi    <= 1'b0;
                bit_cnt <= 3'd7;
                if (byte_cnt == LAST_BYTE) begin
                  state <= TAIL;
                end else begin
                  byte_cnt <= byte_cnt + 1'b1;
                  state    <= GAP;
                end
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
                mosi    <= (byte_cnt == '0) ? cmd[3'(bit_cnt - 3'd1)] : 1'b0;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TAIL: begin
          if (cnt == HALF_LAST) begin
            cnt         <= '0;
            state       <= DONE;
            ss_n        <= 1'b1;
            mosi        <= 1'b0;
            frame       <= shift_reg;
            frame_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          ss_n  <= 1'b1;
          sclk  <= 1'b0;
          mosi  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_poll_scheduler.sv
// tb_spi_poll_scheduler
//   Directed bench for spi_poll_scheduler with small timing parameters.
//   A simple mode-0 slave model returns a programmable response and records
//   what the master sent on mosi.
module tb_spi_poll_scheduler;

  localparam int BYTES = 5;
  localparam int FW    = 8 * BYTES;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          poll_now = 1'b0;
  logic [7:0]    cmd_in = 8'h00;
  logic          miso;
  logic          ss_n;
  logic          sclk;
  logic          mosi;
  logic [FW-1:0] frame;
  logic          frame_valid;
  logic          busy;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  // Slave model state
  logic [FW-1:0] resp = '0;
  logic [FW-1:0] mosi_cap = '0;
  int            idx = 0;

  // Observations collected by one stimulus window
  int            low_count, first_low, last_low, first_rise;
  int            fv_count, fv_first, fv_last, ov_count, ov_first, busy_end;
  logic [FW-1:0] frame_at_fv;
  logic          snap_ss_n, snap_sclk, snap_busy;
  logic [FW-1:0] snap_frame;

  spi_poll_scheduler #(
    .BYTES(BYTES), .CLK_DIV(2), .SS_SETUP(4), .BYTE_GAP(3), .POLL_PERIOD(1000)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .poll_now(poll_now),
    .cmd_in(cmd_in), .miso(miso), .ss_n(ss_n), .sclk(sclk), .mosi(mosi),
    .frame(frame), .frame_valid(frame_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Mode-0 slave: presents the next response bit after each falling sclk,
  // and captures mosi on each rising sclk.
  assign miso = (idx < FW) ? resp[FW-1-idx] : 1'b0;

  always @(negedge ss_n) begin
    idx      = 0;
    mosi_cap = '0;
  end

  always @(negedge sclk) begin
    if (!ss_n) idx = idx + 1;
  end

  always @(posedge sclk) begin
    if (!ss_n) mosi_cap = {mosi_cap[FW-2:0], mosi};
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  // Runs n cycles. Cycle 0 is the current one; start_poll raises poll_now in
  // it. poll_at / rst_at / dis_at schedule events in later cycles (-1 = none).
  task automatic applyStimulus(input int n, input bit start_poll, input int poll_at,
                               input int rst_at, input int dis_at);
    low_count = 0; first_low = -1; last_low = -1; first_rise = -1;
    fv_count = 0; fv_first = -1; fv_last = -1; ov_count = 0; ov_first = -1;
    busy_end = -1; frame_at_fv = '0;
    poll_now = start_poll;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      #1;
      poll_now = (c == poll_at);
      if (c == rst_at) rst = 1'b1;
      if (rst_at >= 0 && c == rst_at + 1) begin
        snap_ss_n  = ss_n;
        snap_sclk  = sclk;
        snap_busy  = busy;
        snap_frame = frame;
        rst = 1'b0;
      end
      if (c == dis_at) enable = 1'b0;
      if (!ss_n) begin
        low_count++;
        if (first_low < 0) first_low = c;
        last_low = c;
      end
      if (sclk && first_rise < 0) first_rise = c;
      if (frame_valid) begin
        fv_count++;
        if (fv_first < 0) fv_first = c;
        fv_last = c;
        frame_at_fv = frame;
      end
      if (overrun) begin
        ov_count++;
        if (ov_first < 0) ov_first = c;
      end
      if (!busy && busy_end < 0) busy_end = c;
    end
    poll_now = 1'b0;
  endtask

  initial begin
    // Reset values
    enable = 1'b0;
    doReset();
    checkOutput("reset_ss_n", 64'(ss_n), 64'd1);
    checkOutput("reset_sclk", 64'(sclk), 64'd0);
    checkOutput("reset_mosi", 64'(mosi), 64'd0);
    checkOutput("reset_frame", 64'(frame), 64'd0);
    checkOutput("reset_fv", 64'(frame_valid), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_overrun", 64'(overrun), 64'd0);

    // Single on-demand frame
    resp   = 40'hA5_3C_0F_F0_81;
    cmd_in = 8'h83;
    applyStimulus(200, 1'b1, -1, -1, -1);
    checkOutput("t1_first_low", 64'(first_low), 64'd1);
    checkOutput("t1_last_low", 64'(last_low), 64'd178);
    checkOutput("t1_low_count", 64'(low_count), 64'd178);
    checkOutput("t1_first_rise", 64'(first_rise), 64'd7);
    checkOutput("t1_fv_cycle", 64'(fv_first), 64'd179);
    checkOutput("t1_fv_count", 64'(fv_count), 64'd1);
    checkOutput("t1_frame_at_fv", 64'(frame_at_fv), 64'hA53C0FF081);
    checkOutput("t1_frame_held", 64'(frame), 64'hA53C0FF081);
    checkOutput("t1_mosi_cmd", 64'(mosi_cap[39:32]), 64'h83);
    checkOutput("t1_mosi_rest", 64'(mosi_cap[31:0]), 64'd0);
    checkOutput("t1_busy_end", 64'(busy_end), 64'd180);

    // Request during a frame is dropped and flagged
    resp   = 40'h01_23_45_67_89;
    cmd_in = 8'h5A;
    applyStimulus(400, 1'b1, 50, -1, -1);
    checkOutput("t3_ov_cycle", 64'(ov_first), 64'd51);
    checkOutput("t3_ov_count", 64'(ov_count), 64'd1);
    checkOutput("t3_fv_count", 64'(fv_count), 64'd1);
    checkOutput("t3_frame", 64'(frame_at_fv), 64'h0123456789);
    checkOutput("t3_busy_end", 64'(busy_end), 64'd180);
    checkOutput("t3_low_count", 64'(low_count), 64'd178);
    checkOutput("t3_mosi_cmd", 64'(mosi_cap[39:32]), 64'h5A);

    // Reset in the middle of a frame, then a clean frame
    resp = 40'hFF_00_AA_55_C3;
    applyStimulus(300, 1'b1, -1, 100, -1);
    checkOutput("t5_ss_n", 64'(snap_ss_n), 64'd1);
    checkOutput("t5_sclk", 64'(snap_sclk), 64'd0);
    checkOutput("t5_busy", 64'(snap_busy), 64'd0);
    checkOutput("t5_frame", 64'(snap_frame), 64'd0);
    checkOutput("t5_fv_count", 64'(fv_count), 64'd0);
    cmd_in = 8'h11;
    applyStimulus(200, 1'b1, -1, -1, -1);
    checkOutput("t5_clean_fv", 64'(fv_first), 64'd179);
    checkOutput("t5_clean_frame", 64'(frame_at_fv), 64'hFF00AA55C3);
    checkOutput("t5_clean_mosi", 64'(mosi_cap[39:32]), 64'h11);

    // Timer-driven frames from reset
    resp   = 40'h12_34_56_78_9A;
    cmd_in = 8'hC1;
    enable = 1'b1;
    doReset();
    applyStimulus(2300, 1'b0, -1, -1, -1);
    checkOutput("t2_fv_count", 64'(fv_count), 64'd2);
    checkOutput("t2_fv_first", 64'(fv_first), 64'd1178);
    checkOutput("t2_fv_last", 64'(fv_last), 64'd2178);
    checkOutput("t2_ov_count", 64'(ov_count), 64'd0);
    checkOutput("t2_frame", 64'(frame_at_fv), 64'h123456789A);

    // Tick and poll_now in the same idle cycle
    doReset();
    applyStimulus(1500, 1'b0, 999, -1, -1);
    checkOutput("t4_fv_count", 64'(fv_count), 64'd1);
    checkOutput("t4_fv_cycle", 64'(fv_first), 64'd1178);
    checkOutput("t4_ov_count", 64'(ov_count), 64'd0);

    // Disable mid-frame: frame completes, timer stays cleared
    enable = 1'b0;
    doReset();
    resp   = 40'h0F_1E_2D_3C_4B;
    enable = 1'b1;
    applyStimulus(1300, 1'b1, -1, -1, 60);
    checkOutput("t6_fv_cycle", 64'(fv_first), 64'd179);
    checkOutput("t6_fv_count", 64'(fv_count), 64'd1);
    checkOutput("t6_low_count", 64'(low_count), 64'd178);
    checkOutput("t6_frame", 64'(frame_at_fv), 64'h0F1E2D3C4B);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
